// File: rtl/simple_dma_wr_seq.sv
// DMA write sequencer: moves cnt stream words to memory over an Avalon-MM write master.
// Handles one word per two cycles at best; the stream is stalled while a write waits on the slave.
module simple_dma_wr_seq #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32,
    parameter int INC_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              int_en_i,
    input  logic              int_type_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic [INC_W-1:0]  inc_i,
    input  logic              irq_clr_i,
    input  logic [DATA_W-1:0] snk_data_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [ADDR_W-1:0] amm_address_o,
    output logic              amm_write_o,
    output logic [DATA_W-1:0] amm_writedata_o,
    input  logic              amm_waitrequest_i,
    output logic              busy_o,
    output logic [CNT_W-1:0]  rem_cnt_o,
    output logic              irq_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        WRITE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             en_d;
    logic             start;
    logic             accept;
    logic             irq_pulse;
    logic [INC_W-1:0] inc_q;

    // en_d keeps tracking en_i through reset, so an enable held across reset
    // is not mistaken for a fresh rising edge.
    always_ff @(posedge clk_i) begin
        en_d <= en_i;
    end

    assign start  = en_i & ~en_d;
    assign accept = (state == WRITE) & ~amm_waitrequest_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        snk_ready_o = 1'b0;
        amm_write_o = 1'b0;
        busy_o      = 1'b1;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start) begin
                    state_nxt = (cnt_i != '0) ? WAIT_DATA : DONE;
                end
            end
            WAIT_DATA: begin
                snk_ready_o = 1'b1;
                if (snk_valid_i) begin
                    state_nxt = WRITE;
                end else if (!en_i) begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                amm_write_o = 1'b1;
                // An abort only takes effect once the issued write is accepted.
                if (accept) begin
                    if (rem_cnt_o == CNT_W'(1)) begin
                        state_nxt = DONE;
                    end else if (!en_i) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_DATA;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            amm_address_o   <= '0;
            amm_writedata_o <= '0;
            rem_cnt_o       <= '0;
            inc_q           <= '0;
        end else begin
            if (state == IDLE && start && cnt_i != '0) begin
                amm_address_o <= addr_i;
                rem_cnt_o     <= cnt_i;
                inc_q         <= inc_i;
            end
            if (state == WAIT_DATA && snk_valid_i) begin
                amm_writedata_o <= snk_data_i;
            end
            if (accept) begin
                amm_address_o <= amm_address_o + ADDR_W'(inc_q);
                if (rem_cnt_o != '0) begin
                    rem_cnt_o <= rem_cnt_o - CNT_W'(1);
                end
            end
        end
    end

    // A new completion beats a simultaneous clear; pulse mode self-clears after one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_o     <= 1'b0;
            irq_pulse <= 1'b0;
        end else if (state == DONE && int_en_i) begin
            irq_o     <= 1'b1;
            irq_pulse <= int_type_i;
        end else if (irq_o && (irq_pulse || irq_clr_i)) begin
            irq_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_simple_dma_wr_seq.sv
// Bench for simple_dma_wr_seq: scenario tasks plus a write scoreboard fed from sink handshakes.
module tb_simple_dma_wr_seq;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b0;
    logic        int_en_i = 1'b0;
    logic        int_type_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] cnt_i = '0;
    logic [15:0] inc_i = '0;
    logic        irq_clr_i = 1'b0;
    logic [31:0] snk_data_i = '0;
    logic        snk_valid_i = 1'b0;
    logic        snk_ready_o;
    logic [31:0] amm_address_o;
    logic        amm_write_o;
    logic [31:0] amm_writedata_o;
    logic        amm_waitrequest_i = 1'b0;
    logic        busy_o;
    logic [31:0] rem_cnt_o;
    logic        irq_o;

    int          total = 0;
    int          bad = 0;
    int          nwr = 0;
    int          wait_states = 0;
    int          wcnt = 0;
    logic        hs_prev = 1'b0;
    logic [31:0] model_addr = '0;
    logic [31:0] model_inc = '0;
    logic [63:0] exp_q[$];

    simple_dma_wr_seq dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .en_i             (en_i),
        .int_en_i         (int_en_i),
        .int_type_i       (int_type_i),
        .addr_i           (addr_i),
        .cnt_i            (cnt_i),
        .inc_i            (inc_i),
        .irq_clr_i        (irq_clr_i),
        .snk_data_i       (snk_data_i),
        .snk_valid_i      (snk_valid_i),
        .snk_ready_o      (snk_ready_o),
        .amm_address_o    (amm_address_o),
        .amm_write_o      (amm_write_o),
        .amm_writedata_o  (amm_writedata_o),
        .amm_waitrequest_i(amm_waitrequest_i),
        .busy_o           (busy_o),
        .rem_cnt_o        (rem_cnt_o),
        .irq_o            (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Slave/sink model: inserts wait states, advances stream data after each
    // handshake and scores every accepted write against the expectation queue.
    always begin
        logic [63:0] e;
        @(negedge clk_i);
        #2;
        if (hs_prev) begin
            snk_data_i = snk_data_i + 32'd1;
            hs_prev = 1'b0;
        end
        if (amm_write_o && wcnt < wait_states) begin
            amm_waitrequest_i = 1'b1;
            wcnt++;
        end else begin
            amm_waitrequest_i = 1'b0;
            wcnt = 0;
        end
        if (amm_write_o && !amm_waitrequest_i) begin
            nwr++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected: got addr=%h data=%h, required no write", amm_address_o, amm_writedata_o);
            end else begin
                e = exp_q.pop_front();
                if ({amm_address_o, amm_writedata_o} !== e) begin
                    bad++;
                    $display("FAIL write_content: got addr=%h data=%h, required addr=%h data=%h",
                             amm_address_o, amm_writedata_o, e[63:32], e[31:0]);
                end
            end
        end
        if (snk_ready_o && snk_valid_i && !rst_i) begin
            exp_q.push_back({model_addr, snk_data_i});
            model_addr = model_addr + model_inc;
            hs_prev = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk_i);
        #3;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        total++;
        if ({snk_ready_o, amm_write_o, busy_o, irq_o} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got ready/write/busy/irq=%b, required 0000", {snk_ready_o, amm_write_o, busy_o, irq_o});
        end
        total++;
        if (amm_address_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_addr: got %h, required 0", amm_address_o);
        end
        total++;
        if (amm_writedata_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: got %h, required 0", amm_writedata_o);
        end
        total++;
        if (rem_cnt_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_rem: got %0d, required 0", rem_cnt_o);
        end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_basic();
        model_addr = 32'h1000;
        model_inc = 32'd4;
        wait_states = 0;
        snk_data_i = 32'hA0;
        snk_valid_i = 1'b1;
        addr_i = 32'h1000;
        cnt_i = 32'd4;
        inc_i = 16'd4;
        int_en_i = 1'b1;
        int_type_i = 1'b1;
        nwr = 0;
        en_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            total++;
            if (amm_write_o !== (k == 2 || k == 4 || k == 6 || k == 8)) begin
                bad++;
                $display("FAIL basic_write_timing: cycle %0d got write=%b", k, amm_write_o);
            end
            total++;
            if (busy_o !== (k >= 1 && k <= 9)) begin
                bad++;
                $display("FAIL basic_busy: cycle %0d got busy=%b", k, busy_o);
            end
            total++;
            if (irq_o !== (k == 10)) begin
                bad++;
                $display("FAIL basic_irq_pulse: cycle %0d got irq=%b", k, irq_o);
            end
        end
        total++;
        if (nwr !== 4 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL basic_count: got writes=%0d pending=%0d, required 4 and 0", nwr, exp_q.size());
        end
        en_i = 1'b0;
        snk_valid_i = 1'b0;
        step();
        step();
    endtask

    task automatic test_waitstates();
        int k = 0;
        int held = 0;
        logic [31:0] rem_exp = 32'd3;
        model_addr = 32'h2000;
        model_inc = 32'd0;
        wait_states = 3;
        snk_data_i = 32'h10;
        snk_valid_i = 1'b1;
        addr_i = 32'h2000;
        cnt_i = 32'd3;
        inc_i = 16'd0;
        int_en_i = 1'b0;
        nwr = 0;
        en_i = 1'b1;
        do begin
            step();
            k++;
            total++;
            if (rem_cnt_o !== rem_exp) begin
                bad++;
                $display("FAIL wait_rem: cycle %0d got %0d, required %0d", k, rem_cnt_o, rem_exp);
            end
            if (amm_write_o) begin
                held++;
                total++;
                if (amm_address_o !== 32'h2000) begin
                    bad++;
                    $display("FAIL wait_addr_fixed: got %h, required 00002000", amm_address_o);
                end
                if (!amm_waitrequest_i) begin
                    total++;
                    if (held !== 4) begin
                        bad++;
                        $display("FAIL wait_hold_len: got %0d cycles, required 4", held);
                    end
                    held = 0;
                    rem_exp = rem_exp - 32'd1;
                end
            end
        end while (busy_o && k < 40);
        total++;
        if (busy_o !== 1'b0 || nwr !== 3 || rem_cnt_o !== 32'd0) begin
            bad++;
            $display("FAIL wait_end: got busy=%b writes=%0d rem=%0d, required 0/3/0", busy_o, nwr, rem_cnt_o);
        end
        en_i = 1'b0;
        snk_valid_i = 1'b0;
        wait_states = 0;
        step();
        step();
    endtask

    task automatic test_wrap();
        int k = 0;
        model_addr = 32'hFFFF_FFF8;
        model_inc = 32'd8;
        snk_data_i = 32'h77;
        snk_valid_i = 1'b1;
        addr_i = 32'hFFFF_FFF8;
        cnt_i = 32'd2;
        inc_i = 16'd8;
        nwr = 0;
        en_i = 1'b1;
        do begin
            step();
            k++;
        end while (busy_o && k < 20);
        total++;
        if (busy_o !== 1'b0 || nwr !== 2 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL wrap_end: got busy=%b writes=%0d pending=%0d, required 0/2/0", busy_o, nwr, exp_q.size());
        end
        total++;
        if (amm_address_o !== 32'h0000_0008) begin
            bad++;
            $display("FAIL wrap_next_addr: got %h, required 00000008", amm_address_o);
        end
        en_i = 1'b0;
        snk_valid_i = 1'b0;
        step();
        step();
    endtask

    task automatic test_abort();
        int k = 0;
        model_addr = 32'h3000;
        model_inc = 32'd4;
        wait_states = 3;
        snk_data_i = 32'h50;
        snk_valid_i = 1'b1;
        addr_i = 32'h3000;
        cnt_i = 32'd5;
        inc_i = 16'd4;
        int_en_i = 1'b1;
        int_type_i = 1'b0;
        nwr = 0;
        en_i = 1'b1;
        step();
        step();
        total++;
        if ({amm_write_o, amm_waitrequest_i} !== 2'b11) begin
            bad++;
            $display("FAIL abort_in_write: got write/wait=%b, required 11", {amm_write_o, amm_waitrequest_i});
        end
        en_i = 1'b0;
        snk_valid_i = 1'b0;
        do begin
            step();
            k++;
            if (amm_write_o) begin
                total++;
                if (amm_address_o !== 32'h3000) begin
                    bad++;
                    $display("FAIL abort_held_addr: got %h, required 00003000", amm_address_o);
                end
            end
        end while (busy_o && k < 20);
        total++;
        if (busy_o !== 1'b0 || rem_cnt_o !== 32'd4 || irq_o !== 1'b0 || nwr !== 1) begin
            bad++;
            $display("FAIL abort_end: got busy=%b rem=%0d irq=%b writes=%0d, required 0/4/0/1",
                     busy_o, rem_cnt_o, irq_o, nwr);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({busy_o, amm_write_o, irq_o} !== 3'b000) begin
                bad++;
                $display("FAIL abort_idle: got busy/write/irq=%b, required 000", {busy_o, amm_write_o, irq_o});
            end
        end
        wait_states = 0;
    endtask

    task automatic test_level_irq();
        cnt_i = 32'd0;
        int_en_i = 1'b1;
        int_type_i = 1'b0;
        snk_valid_i = 1'b0;
        nwr = 0;
        en_i = 1'b1;
        step();
        total++;
        if ({amm_write_o, irq_o} !== 2'b00) begin
            bad++;
            $display("FAIL level_done_cycle: got write/irq=%b, required 00", {amm_write_o, irq_o});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (irq_o !== 1'b1) begin
                bad++;
                $display("FAIL level_held: cycle %0d got irq=%b, required 1", i + 2, irq_o);
            end
        end
        en_i = 1'b0;
        step();
        en_i = 1'b1;
        step();
        irq_clr_i = 1'b1;
        step();
        irq_clr_i = 1'b0;
        total++;
        if (irq_o !== 1'b1) begin
            bad++;
            $display("FAIL level_set_wins: got irq=%b, required 1", irq_o);
        end
        step();
        total++;
        if (irq_o !== 1'b1) begin
            bad++;
            $display("FAIL level_after_set: got irq=%b, required 1", irq_o);
        end
        en_i = 1'b0;
        irq_clr_i = 1'b1;
        step();
        irq_clr_i = 1'b0;
        total++;
        if (irq_o !== 1'b0 || nwr !== 0) begin
            bad++;
            $display("FAIL level_clear: got irq=%b writes=%0d, required 0 and 0", irq_o, nwr);
        end
        step();
    endtask

    task automatic test_reset_mid();
        addr_i = 32'h4000;
        cnt_i = 32'd4;
        inc_i = 16'd4;
        int_en_i = 1'b1;
        int_type_i = 1'b1;
        snk_valid_i = 1'b0;
        nwr = 0;
        en_i = 1'b1;
        step();
        step();
        total++;
        if ({snk_ready_o, busy_o} !== 2'b11) begin
            bad++;
            $display("FAIL rstmid_waiting: got ready/busy=%b, required 11", {snk_ready_o, busy_o});
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        total++;
        if ({snk_ready_o, amm_write_o, busy_o, irq_o, amm_address_o, amm_writedata_o, rem_cnt_o} !== 100'h0) begin
            bad++;
            $display("FAIL rstmid_outputs: got ready=%b write=%b busy=%b irq=%b addr=%h data=%h rem=%0d, required all 0",
                     snk_ready_o, amm_write_o, busy_o, irq_o, amm_address_o, amm_writedata_o, rem_cnt_o);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({busy_o, irq_o} !== 2'b00) begin
                bad++;
                $display("FAIL rstmid_no_restart: got busy/irq=%b, required 00", {busy_o, irq_o});
            end
        end
        en_i = 1'b0;
        step();
        en_i = 1'b1;
        step();
        total++;
        if ({busy_o, rem_cnt_o} !== {1'b1, 32'd4}) begin
            bad++;
            $display("FAIL rstmid_fresh_edge: got busy=%b rem=%0d, required 1 and 4", busy_o, rem_cnt_o);
        end
        en_i = 1'b0;
        step();
        step();
        total++;
        if ({busy_o, irq_o} !== 2'b00 || nwr !== 0) begin
            bad++;
            $display("FAIL rstmid_abort: got busy/irq=%b writes=%0d, required 00 and 0", {busy_o, irq_o}, nwr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_waitstates();
        test_wrap();
        test_abort();
        test_level_irq();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
